// File: rtl/alu_mdu.sv
// alu_mdu: registered MIPS ALU with iterative shift-add multiply and restoring divide,
// valid/ready handshakes on both sides and flags captured on entry to DONE.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             neg,
    output logic             eq,
    output logic             lt,
    output logic             div_zero
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t st;
    logic [SHW:0] cnt;
    logic [3:0] opr;
    logic [WIDTH-1:0] ar, br, hi, lo, alu, ma, mb, hi_n, lo_n, quo, rem, fin_lo, fin_hi;
    logic [WIDTH:0] sum;
    logic [WIDTH+1:0] trial;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [SHW-1:0] sh;
    logic rdy, sgn, dz, acc;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    // rdy keeps in_ready low while reset is held and until the first edge after release
    assign in_ready  = rdy && (st == IDLE || (st == DONE && out_ready));
    assign out_valid = (st == DONE);
    assign acc       = in_valid && in_ready;
    assign sh        = a[SHW-1:0];

    always_comb begin
        alu = '0;
        case (op)
            4'd0:  alu = a + b;
            4'd1:  alu = a - b;
            4'd2:  alu = a & b;
            4'd3:  alu = a | b;
            4'd4:  alu = a ^ b;
            4'd5:  alu = ~(a | b);
            4'd6:  alu = b << sh;
            4'd7:  alu = b >> sh;
            4'd8:  alu = $signed(b) >>> sh;
            4'd9:  alu = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'd10: alu = WIDTH'($signed(a) < $signed(b));
            4'd11: alu = WIDTH'(a < b);
            default: alu = '0;
        endcase
    end

    // one shift-add (MUL) or restoring-subtract (DIV) step on magnitudes, plus sign fix-up
    always_comb begin
        sgn    = ~opr[0];
        ma     = mag(ar, sgn);
        mb     = mag(br, sgn);
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, ma} : '0);
        trial  = {1'b0, hi, lo[WIDTH-1]} - {2'b0, mb};
        hi_n   = opr[1] ? (trial[WIDTH+1] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : trial[WIDTH-1:0]) : sum[WIDTH:1];
        lo_n   = opr[1] ? {lo[WIDTH-2:0], ~trial[WIDTH+1]} : {sum[0], lo[WIDTH-1:1]};
        prod   = {hi_n, lo_n};
        prod_s = (sgn && (ar[WIDTH-1] ^ br[WIDTH-1])) ? -prod : prod;
        quo    = (sgn && (ar[WIDTH-1] ^ br[WIDTH-1])) ? -lo_n : lo_n;
        rem    = (sgn && ar[WIDTH-1]) ? -hi_n : hi_n;
        dz     = opr[1] && (br == '0);
        fin_lo = opr[1] ? (dz ? '1 : quo) : prod_s[WIDTH-1:0];
        fin_hi = opr[1] ? (dz ? ar : rem) : prod_s[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            rdy       <= 1'b0;
            cnt       <= '0;
            opr       <= '0;
            ar        <= '0;
            br        <= '0;
            hi        <= '0;
            lo        <= '0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (acc) begin
                opr <= op;
                ar  <= a;
                br  <= b;
                if (op[3:2] == 2'b11) begin
                    st  <= BUSY;
                    cnt <= (SHW+1)'(WIDTH);
                    hi  <= '0;
                    lo  <= op[1] ? mag(a, ~op[0]) : mag(b, ~op[0]);
                end else begin
                    st        <= DONE;
                    result    <= alu;
                    result_hi <= '0;
                    zero      <= (alu == '0);
                    neg       <= alu[WIDTH-1];
                    eq        <= (a == b);
                    lt        <= $signed(a) < $signed(b);
                    div_zero  <= 1'b0;
                end
            end else if (st == BUSY) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt - 1'b1;
                if (cnt == (SHW+1)'(1)) begin
                    st        <= DONE;
                    result    <= fin_lo;
                    result_hi <= fin_hi;
                    zero      <= (fin_lo == '0);
                    neg       <= fin_lo[WIDTH-1];
                    eq        <= (ar == br);
                    lt        <= $signed(ar) < $signed(br);
                    div_zero  <= dz;
                end
            end else if (st == DONE && out_ready) begin
                st <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vector table for alu_mdu plus reset-abort and backpressure sequences.
module tb_alu_mdu;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, zero, neg, eq, lt, div_zero;
    logic [3:0] op = 0;
    logic [31:0] a = 0, b = 0, result, result_hi;
    int nvec = 0, nfail = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .zero(zero), .neg(neg), .eq(eq), .lt(lt), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, r, h;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    vec_t tv[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        int k;
        @(negedge clk);
        in_valid = 1; op = o; a = x; b = y;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0; a = $urandom; b = $urandom; op = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        tv[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 5'b01000, 1};
        tv[1]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 5'b01010, 1};
        tv[2]  = '{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 5'b00010, 1};
        tv[3]  = '{4'd3,  32'h000000F0, 32'h0000000F, 32'h000000FF, 32'h0, 5'b00000, 1};
        tv[4]  = '{4'd4,  32'h12345678, 32'h12345678, 32'h00000000, 32'h0, 5'b10100, 1};
        tv[5]  = '{4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 5'b01100, 1};
        tv[6]  = '{4'd6,  32'h00000024, 32'h00000001, 32'h00000010, 32'h0, 5'b00000, 1};
        tv[7]  = '{4'd7,  32'h00000004, 32'hF0000000, 32'h0F000000, 32'h0, 5'b00000, 1};
        tv[8]  = '{4'd8,  32'h00000004, 32'hF0000000, 32'hFF000000, 32'h0, 5'b01000, 1};
        tv[9]  = '{4'd9,  32'h00000000, 32'h00001234, 32'h12340000, 32'h0, 5'b00010, 1};
        tv[10] = '{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 5'b00010, 1};
        tv[11] = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 5'b10010, 1};
        tv[12] = '{4'd12, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 5'b01010, 33};
        tv[13] = '{4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 5'b00100, 33};
        tv[14] = '{4'd14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 5'b01010, 33};
        tv[15] = '{4'd15, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 5'b01001, 33};
        tv[16] = '{4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 5'b01010, 33};
        tv[17] = '{4'd14, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 5'b01000, 33};
        tv[18] = '{4'd13, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 5'b10100, 33};
        tv[19] = '{4'd8,  32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 32'h0, 5'b01000, 1};

        #12;
        chk("reset_in_ready", {63'b0, in_ready}, 0);
        chk("reset_out_valid", {63'b0, out_valid}, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {63'b0, in_ready}, 1);

        foreach (tv[i]) begin
            issue(tv[i].op, tv[i].a, tv[i].b, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(tv[i].lat));
            chk($sformatf("v%0d_result", i), {result_hi, result}, {tv[i].h, tv[i].r});
            chk($sformatf("v%0d_flags", i), {59'b0, zero, neg, eq, lt, div_zero}, {59'b0, tv[i].f});
        end

        // reset in the middle of a MUL aborts it
        @(negedge clk);
        in_valid = 1; op = 4'd12; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("mul_busy_no_valid", {63'b0, out_valid}, 0);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_outputs", {in_ready, out_valid, zero, neg, eq, lt, div_zero, result, result_hi}, 71'b0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_release_ready", {62'b0, in_ready, out_valid}, 64'b10);
        begin
            logic seen = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                seen |= out_valid;
            end
            chk("aborted_no_result", {63'b0, seen}, 0);
        end

        // backpressure: result and flags hold, no accept, release accepts same edge
        out_ready = 0;
        issue(4'd1, 32'd9, 32'd9, lat);
        chk("bp_latency", 64'(lat), 1);
        @(negedge clk);
        in_valid = 1; op = 4'd0; a = 32'd2; b = 32'd3;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", k), {result, zero, eq, out_valid, in_ready}, {32'd0, 4'b1110});
        end
        @(negedge clk);
        out_ready = 1;
        #1;
        chk("bp_release_ready", {63'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("bp_next_result", {31'b0, out_valid, result}, {31'b0, 1'b1, 32'd5});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, registered successor of the combinational MIPS ALU.
- Adds an iterative multiply/divide unit, valid/ready handshakes on input and output, and registered result flags.
- Sits in the EX stage; the pipeline stalls on in_ready/out_valid while MUL/DIV iterate.

Parameters:
- WIDTH, 32: operand/result width; even, ≥8.
- SHW, $clog2(WIDTH): shift-amount bits (derived, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation can be accepted.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 LUI, 10 SLT, 11 SLTU, 12 MUL, 13 MULU, 14 DIV, 15 DIVU.
- a  in  WIDTH  operand A; shift amount for shifts.
- b  in  WIDTH  operand B; value shifted or loaded.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  low product / quotient / ALU result.
- result_hi  out  WIDTH  high product / remainder; 0 for single-cycle ops.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- eq  out  1  captured a == b.
- lt  out  1  captured a < b, signed.
- div_zero  out  1  DIV/DIVU with b == 0.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE; all outputs and internal registers clear to 0.
  - in_ready is 1 from the first clock edge after release.
  - Reset during BUSY aborts the operation; no result is produced.
- Accept: in_valid && in_ready on a rising edge. Operands and op are captured. a/b changes after accept have no effect.
- FSM states: IDLE, BUSY, DONE.
  - IDLE + accept of a single-cycle op (0–11) -> DONE.
  - IDLE + accept of op 12–15 -> BUSY, counter = WIDTH.
  - BUSY: one iteration per cycle. Counter reaches 0 -> DONE.
  - DONE + out_ready, no accept -> IDLE.
  - DONE + out_ready + accept -> DONE or BUSY, per the new op (back-to-back).
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- out_valid = (state == DONE).
- Latency, accept at edge N:
  - Ops 0–11: out_valid high after edge N+1.
  - Ops 12–15: out_valid high after edge N+1+WIDTH.
- While out_valid && !out_ready: result, result_hi and all flags hold stable. No new accept.
- Single-cycle ops (result_hi = 0):
  - Shifts: b shifted by a[SHW-1:0]; upper bits of a ignored. SRA is arithmetic.
  - LUI: {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - SLT/SLTU: result = 1 or 0.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
- MUL/MULU: shift-add over WIDTH iterations. {result_hi, result} = full 2·WIDTH-bit product, signed (MUL) or unsigned (MULU).
  - MUL uses magnitudes, then negates the product if the operand signs differ.
- DIV/DIVU: restoring division over WIDTH iterations. result = quotient, result_hi = remainder.
  - Signed: quotient negative iff operand signs differ; remainder takes the sign of a.
  - Overflow, a = most-negative and b = -1: result = a, result_hi = 0, div_zero = 0.
  - b == 0: result = all ones, result_hi = a, div_zero = 1. Still takes the full WIDTH cycles.
- Flags update only on entry to DONE.
  - zero/neg come from result (low word).
  - eq/lt come from the captured operands.
  - div_zero is 0 for all ops other than DIV/DIVU.

Test Plan:
- Reset mid-MUL: assert rst_n low at cycle 5 of a MUL -> all outputs 0 immediately, in_ready = 1 after release, no out_valid.
- WIDTH=32, ADD a=0x7FFFFFFF b=1 with out_ready=1 -> out_valid one cycle later; result=0x80000000, neg=1, zero=0, lt=0, eq=0.
- SRA a=4 b=0xF0000000 -> result=0xFF000000. Then LUI b=0x00001234 -> result=0x12340000. Back-to-back, 1 result per cycle.
- MUL a=-3 b=7 -> out_valid exactly 33 cycles after accept; {result_hi, result}=0xFFFFFFFF_FFFFFFEB. MULU a=b=0xFFFFFFFF -> 0xFFFFFFFE_00000001.
- DIV a=-7 b=2 -> result=-3, result_hi=-1. DIVU a=5 b=0 -> result=0xFFFFFFFF, result_hi=5, div_zero=1. DIV a=0x80000000 b=-1 -> result=0x80000000, result_hi=0.
- Backpressure: hold out_ready=0 for 10 cycles after SUB a=b=9 -> result=0, zero=1, eq=1 stable throughout, in_ready=0. Release with in_valid high -> next op accepted the same edge.
